// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants, state encoding and per-state control decode for the
// multi-cycle MIPS controller.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_NOR = 6'b100111;
    localparam logic [5:0] F_XOR = 6'b100110;

    localparam logic [2:0] AC3_ADD = 3'b010;
    localparam logic [2:0] AC3_SUB = 3'b110;
    localparam logic [2:0] AC3_AND = 3'b000;
    localparam logic [2:0] AC3_OR  = 3'b001;
    localparam logic [2:0] AC3_SLT = 3'b111;

    localparam logic [3:0] AC4_ADD = 4'b0010;
    localparam logic [3:0] AC4_SUB = 4'b0110;
    localparam logic [3:0] AC4_AND = 4'b0000;
    localparam logic [3:0] AC4_OR  = 4'b0001;
    localparam logic [3:0] AC4_SLT = 4'b0111;
    localparam logic [3:0] AC4_NOR = 4'b1100;
    localparam logic [3:0] AC4_XOR = 4'b0011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_IMM   = 2'b11
    } aluop_t;

    typedef enum logic [2:0] {
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_NOR, FN_XOR
    } alufn_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECUTE, S_ALUWB, S_BRANCH, S_IMMEXEC, S_IMMWB, S_JUMP
    } state_t;

    typedef struct packed {
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       regwrite;
        logic       alusrca;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        aluop_t     aluop;
        logic       done;
    } ctrl_t;

    function automatic logic funct_legal(input logic [5:0] funct, input logic ext);
        case (funct)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: return 1'b1;
            F_NOR, F_XOR:                     return ext;
            default:                          return 1'b0;
        endcase
    endfunction

    // FETCH doubles as the "illegal opcode" target out of DECODE.
    function automatic state_t decode_target(input logic [5:0] op, input logic ext);
        case (op)
            OP_LW, OP_SW:             return S_MEMADR;
            OP_RTYPE:                 return S_EXECUTE;
            OP_BEQ:                   return S_BRANCH;
            OP_ADDI:                  return S_IMMEXEC;
            OP_ANDI, OP_ORI, OP_SLTI: return ext ? S_IMMEXEC : S_FETCH;
            OP_J:                     return S_JUMP;
            default:                  return S_FETCH;
        endcase
    endfunction

    function automatic state_t next_state(input state_t s, input logic [5:0] op, input logic ext);
        case (s)
            S_FETCH:   return S_DECODE;
            S_DECODE:  return decode_target(op, ext);
            S_MEMADR:  return (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   return S_MEMWB;
            S_EXECUTE: return S_ALUWB;
            S_IMMEXEC: return S_IMMWB;
            default:   return S_FETCH;
        endcase
    endfunction

    function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
            S_DECODE:  c.alusrcb = 2'b11;
            S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            S_MEMRD:   c.iord = 1'b1;
            S_MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
            S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; c.done = 1'b1; end
            S_EXECUTE: begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
            S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; c.done = 1'b1; end
            S_BRANCH:  begin
                c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01;
                c.branch = 1'b1; c.done = 1'b1;
            end
            S_IMMEXEC: begin
                c.alusrca = 1'b1; c.alusrcb = 2'b10;
                c.aluop = (op == OP_ADDI) ? ALUOP_ADD : ALUOP_IMM;
            end
            S_IMMWB:   begin c.regwrite = 1'b1; c.done = 1'b1; end
            S_JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; c.done = 1'b1; end
            default:   ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath signal bundle; the controller is the master side.
interface multicycle_ctrl_if #(parameter int ALUCTRL_W = 3);
    logic [5:0]           op;
    logic [5:0]           funct;
    logic                 zero;
    logic                 pcen;
    logic                 memwrite;
    logic                 irwrite;
    logic                 regwrite;
    logic                 alusrca;
    logic                 iord;
    logic                 memtoreg;
    logic                 regdst;
    logic [1:0]           alusrcb;
    logic [1:0]           pcsrc;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic                 illegal;
    logic                 instr_done;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
               alusrcb, pcsrc, alucontrol, illegal, instr_done
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
               alusrcb, pcsrc, alucontrol, illegal, instr_done
    );
endinterface

// File: rtl/multicycle_ctrl_aludec.sv
// Combinational ALU decoder: aluop/op/funct to a 3- or 4-bit alucontrol code.
module alu_decoder_ext
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter bit EXT_OPS   = 1'b0
) (
    input  aluop_t               aluop,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alucontrol
);

    alufn_t fn;

    always_comb begin
        fn = FN_ADD;
        case (aluop)
            ALUOP_SUB:   fn = FN_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_SUB:   fn = FN_SUB;
                    F_AND:   fn = FN_AND;
                    F_OR:    fn = FN_OR;
                    F_SLT:   fn = FN_SLT;
                    F_NOR:   if (EXT_OPS) fn = FN_NOR;
                    F_XOR:   if (EXT_OPS) fn = FN_XOR;
                    default: fn = FN_ADD;
                endcase
            end
            ALUOP_IMM: begin
                case (op)
                    OP_ANDI: fn = FN_AND;
                    OP_ORI:  fn = FN_OR;
                    OP_SLTI: fn = FN_SLT;
                    default: fn = FN_ADD;
                endcase
            end
            default:     fn = FN_ADD;
        endcase
    end

    if (ALUCTRL_W == 4) begin : g_w4
        always_comb begin
            case (fn)
                FN_SUB:  alucontrol = AC4_SUB;
                FN_AND:  alucontrol = AC4_AND;
                FN_OR:   alucontrol = AC4_OR;
                FN_SLT:  alucontrol = AC4_SLT;
                FN_NOR:  alucontrol = AC4_NOR;
                FN_XOR:  alucontrol = AC4_XOR;
                default: alucontrol = AC4_ADD;
            endcase
        end
    end else begin : g_w3
        always_comb begin
            case (fn)
                FN_SUB:  alucontrol = AC3_SUB;
                FN_AND:  alucontrol = AC3_AND;
                FN_OR:   alucontrol = AC3_OR;
                FN_SLT:  alucontrol = AC3_SLT;
                default: alucontrol = AC3_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM; control word is registered alongside the state.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter bit EXT_OPS   = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);

    state_t state;
    state_t nxt;
    ctrl_t  ctl;
    ctrl_t  cur;
    logic   op_bad;
    logic   funct_bad;

    assign nxt = next_state(state, bus.op, EXT_OPS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            ctl   <= ctrl_of(S_FETCH, bus.op);
        end else begin
            state <= nxt;
            ctl   <= ctrl_of(nxt, bus.op);
        end
    end

    // Reset shows FETCH selects immediately, even mid-instruction.
    always_comb begin
        cur = ctl;
        if (reset) cur = ctrl_of(S_FETCH, bus.op);
    end

    assign op_bad    = (state == S_DECODE) && (decode_target(bus.op, EXT_OPS) == S_FETCH);
    assign funct_bad = (state == S_ALUWB) && !funct_legal(bus.funct, EXT_OPS);

    assign bus.pcen       = (cur.pcwrite | (cur.branch & bus.zero)) & ~reset;
    assign bus.irwrite    = cur.irwrite & ~reset;
    assign bus.memwrite   = cur.memwrite & ~reset;
    assign bus.regwrite   = cur.regwrite & ~funct_bad & ~reset;
    assign bus.illegal    = (op_bad | funct_bad) & ~reset;
    assign bus.instr_done = cur.done & ~reset;
    assign bus.alusrca    = cur.alusrca;
    assign bus.iord       = cur.iord;
    assign bus.memtoreg   = cur.memtoreg;
    assign bus.regdst     = cur.regdst;
    assign bus.alusrcb    = cur.alusrcb;
    assign bus.pcsrc      = cur.pcsrc;

    alu_decoder_ext #(
        .ALUCTRL_W (ALUCTRL_W),
        .EXT_OPS   (EXT_OPS)
    ) u_aludec (
        .aluop      (cur.aluop),
        .op         (bus.op),
        .funct      (bus.funct),
        .alucontrol (bus.alucontrol)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a base (W=3) and an extended (W=4, EXT_OPS) instance.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.ALUCTRL_W(3)) if3 ();
    multicycle_ctrl_if #(.ALUCTRL_W(4)) if4 ();

    multicycle_ctrl #(.ALUCTRL_W(3), .EXT_OPS(1'b0)) dut3 (.clk(clk), .reset(reset), .bus(if3));
    multicycle_ctrl #(.ALUCTRL_W(4), .EXT_OPS(1'b1)) dut4 (.clk(clk), .reset(reset), .bus(if4));

    // {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
    //  alusrcb[1:0], pcsrc[1:0], alucontrol[3:0], illegal, instr_done}
    logic [17:0] obs3, obs4;
    assign obs3 = {if3.pcen, if3.memwrite, if3.irwrite, if3.regwrite, if3.alusrca, if3.iord,
                   if3.memtoreg, if3.regdst, if3.alusrcb, if3.pcsrc, 1'b0, if3.alucontrol,
                   if3.illegal, if3.instr_done};
    assign obs4 = {if4.pcen, if4.memwrite, if4.irwrite, if4.regwrite, if4.alusrca, if4.iord,
                   if4.memtoreg, if4.regdst, if4.alusrcb, if4.pcsrc, if4.alucontrol,
                   if4.illegal, if4.instr_done};

    localparam logic [17:0] RST_EXP = {8'b0, 2'b01, 2'b00, 4'b0010, 2'b00};

    typedef struct {
        bit          sel;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int unsigned cyc;
        logic [3:0]  alu2;
        logic        done_l;
        logic        we_l;
        logic        pcen_l;
    } vec_t;

    vec_t        vecs[$];
    logic [17:0] seen[8];

    // ---------------- reference model ----------------
    function automatic string kind_of(input bit ext, input logic [5:0] op);
        case (op)
            6'b100011: return "lw";
            6'b101011: return "sw";
            6'b000000: return "r";
            6'b000100: return "beq";
            6'b000010: return "j";
            6'b001000: return "imm";
            6'b001100, 6'b001101, 6'b001010: return ext ? "imm" : "bad";
            default:   return "bad";
        endcase
    endfunction

    function automatic int unsigned cpi(input bit ext, input logic [5:0] op);
        string k;
        k = kind_of(ext, op);
        if (k == "lw") return 5;
        if (k == "sw" || k == "r" || k == "imm") return 4;
        if (k == "beq" || k == "j") return 3;
        return 2;
    endfunction

    function automatic string fname(input logic [5:0] funct, input bit ext);
        case (funct)
            6'b100000: return "add";
            6'b100010: return "sub";
            6'b100100: return "and";
            6'b100101: return "or";
            6'b101010: return "slt";
            6'b100111: return ext ? "nor" : "";
            6'b100110: return ext ? "xor" : "";
            default:   return "";
        endcase
    endfunction

    function automatic logic [3:0] acode(input string fn);
        if (fn == "sub") return 4'b0110;
        if (fn == "and") return 4'b0000;
        if (fn == "or")  return 4'b0001;
        if (fn == "slt") return 4'b0111;
        if (fn == "nor") return 4'b1100;
        if (fn == "xor") return 4'b0011;
        return 4'b0010;
    endfunction

    function automatic string imm_fn(input logic [5:0] op);
        if (op == 6'b001100) return "and";
        if (op == 6'b001101) return "or";
        if (op == 6'b001010) return "slt";
        return "add";
    endfunction

    function automatic logic [17:0] model(input bit ext, input logic [5:0] op, input logic [5:0] funct,
                                          input logic zero, input int unsigned step);
        string k, fn, alu;
        logic pcen, memw, irw, regw, srca, iord, mtr, rdst, ill, done;
        logic [1:0] srcb, psrc;
        k = kind_of(ext, op);
        fn = fname(funct, ext);
        alu = "add";
        {pcen, memw, irw, regw, srca, iord, mtr, rdst, ill, done} = '0;
        srcb = 2'b00;
        psrc = 2'b00;
        if (step == 0) begin
            irw = 1'b1; pcen = 1'b1; srcb = 2'b01;
        end else if (step == 1) begin
            srcb = 2'b11; ill = (k == "bad");
        end else if (k == "lw" || k == "sw") begin
            if (step == 2) begin srca = 1'b1; srcb = 2'b10; end
            else if (step == 3 && k == "lw") iord = 1'b1;
            else if (step == 3) begin iord = 1'b1; memw = 1'b1; done = 1'b1; end
            else begin mtr = 1'b1; regw = 1'b1; done = 1'b1; end
        end else if (k == "r") begin
            if (step == 2) begin srca = 1'b1; alu = fn; end
            else begin rdst = 1'b1; regw = (fn != ""); ill = (fn == ""); done = 1'b1; end
        end else if (k == "beq") begin
            srca = 1'b1; alu = "sub"; psrc = 2'b01; pcen = zero; done = 1'b1;
        end else if (k == "imm") begin
            if (step == 2) begin srca = 1'b1; srcb = 2'b10; alu = imm_fn(op); end
            else begin regw = 1'b1; done = 1'b1; end
        end else if (k == "j") begin
            psrc = 2'b10; pcen = 1'b1; done = 1'b1;
        end
        return {pcen, memw, irw, regw, srca, iord, mtr, rdst, srcb, psrc, acode(alu), ill, done};
    endfunction

    // ---------------- bench plumbing ----------------
    task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [5:0] op, input logic [5:0] funct, input logic zero);
        if (sel) begin if4.op = op; if4.funct = funct; if4.zero = zero; end
        else     begin if3.op = op; if3.funct = funct; if3.zero = zero; end
    endtask

    task automatic run_steps(input bit sel, input logic [5:0] op, input logic [5:0] funct,
                             input logic zero, input int unsigned n, input string tag);
        drive(sel, op, funct, zero);
        for (int unsigned s = 0; s < n; s++) begin
            @(negedge clk);
            seen[s] = sel ? obs4 : obs3;
            check($sformatf("%s.step%0d", tag, s), seen[s], model(sel, op, funct, zero, s));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input bit sel, input int unsigned n, input string tag);
        reset = 1'b1;
        for (int unsigned c = 0; c < n; c++) begin
            @(negedge clk);
            check($sformatf("%s.rst%0d", tag, c), sel ? obs4 : obs3, RST_EXP);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    function automatic void add(input bit sel, input logic [5:0] op, input logic [5:0] funct,
                                input logic zero, input int unsigned cyc, input logic [3:0] alu2,
                                input logic done_l, input logic we_l, input logic pcen_l);
        vec_t v;
        v.sel = sel; v.op = op; v.funct = funct; v.zero = zero; v.cyc = cyc;
        v.alu2 = alu2; v.done_l = done_l; v.we_l = we_l; v.pcen_l = pcen_l;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [5:0] ops[9];
        logic [5:0] fns[7];
        bit         cur_sel;

        //  sel  op         funct      z  cyc alu2     done we pcen
        add(0, 6'b100011, 6'b000000, 0, 5, 4'b0010, 1, 1, 0);
        add(0, 6'b000000, 6'b100010, 0, 4, 4'b0110, 1, 1, 0);
        add(0, 6'b000100, 6'b000000, 1, 3, 4'b0110, 1, 0, 1);
        add(0, 6'b000100, 6'b000000, 0, 3, 4'b0110, 1, 0, 0);
        add(0, 6'b101011, 6'b000000, 0, 4, 4'b0010, 1, 1, 0);
        add(0, 6'b000010, 6'b000000, 0, 3, 4'b0010, 1, 0, 1);
        add(0, 6'b001000, 6'b000000, 0, 4, 4'b0010, 1, 1, 0);
        add(0, 6'b000000, 6'b100000, 0, 4, 4'b0010, 1, 1, 0);
        add(0, 6'b000000, 6'b100111, 0, 4, 4'b0010, 1, 0, 0);
        add(0, 6'b111111, 6'b000000, 0, 2, 4'b0010, 0, 0, 0);
        add(0, 6'b001100, 6'b000000, 0, 2, 4'b0010, 0, 0, 0);
        add(1, 6'b001101, 6'b000000, 0, 4, 4'b0001, 1, 1, 0);
        add(1, 6'b000000, 6'b100111, 0, 4, 4'b1100, 1, 1, 0);
        add(1, 6'b000000, 6'b100110, 0, 4, 4'b0011, 1, 1, 0);
        add(1, 6'b001010, 6'b000000, 0, 4, 4'b0111, 1, 1, 0);
        add(1, 6'b001100, 6'b000000, 0, 4, 4'b0000, 1, 1, 0);
        add(1, 6'b000000, 6'b101010, 0, 4, 4'b0111, 1, 1, 0);
        add(1, 6'b000000, 6'b000111, 0, 4, 4'b0010, 1, 0, 0);
        add(1, 6'b000100, 6'b000000, 1, 3, 4'b0110, 1, 0, 1);

        reset = 1'b1;
        drive(0, 6'b111111, 6'b000000, 1'b0);
        drive(1, 6'b111111, 6'b000000, 1'b0);
        do_reset(0, 2, "init");
        cur_sel = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].sel != cur_sel) begin
                cur_sel = vecs[i].sel;
                do_reset(cur_sel, 2, "swap");
            end
            run_steps(vecs[i].sel, vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].cyc,
                      $sformatf("vec%0d", i));
            if (vecs[i].cyc > 2)
                check($sformatf("vec%0d.alu", i), {14'b0, seen[2][5:2]}, {14'b0, vecs[i].alu2});
            check($sformatf("vec%0d.last", i),
                  {15'b0, seen[vecs[i].cyc-1][0],
                   seen[vecs[i].cyc-1][14] | seen[vecs[i].cyc-1][16], seen[vecs[i].cyc-1][17]},
                  {15'b0, vecs[i].done_l, vecs[i].we_l, vecs[i].pcen_l});
        end

        // lw aborted by reset while in MEMRD, then a clean lw
        do_reset(0, 2, "pre_abort");
        run_steps(0, 6'b100011, 6'b000000, 1'b0, 3, "abort");
        do_reset(0, 1, "abort");
        run_steps(0, 6'b100011, 6'b000000, 1'b0, 5, "post_abort");

        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                6'b001100, 6'b001101, 6'b001010, 6'b000010};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111, 6'b100110};
        for (int s = 0; s < 2; s++) begin
            do_reset(s[0], 1, "rand");
            for (int n = 0; n < 150; n++) begin
                logic [5:0] op, fn;
                logic       z;
                int unsigned r;
                r  = $urandom_range(0, 10);
                op = (r > 8) ? 6'($urandom) : ops[r];
                r  = $urandom_range(0, 8);
                fn = (r > 6) ? 6'($urandom) : fns[r];
                z  = 1'($urandom);
                run_steps(s[0], op, fn, z, cpi(s[0], op), $sformatf("rand%0d_%0d", s, n));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the 32-bit MIPS datapath: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback, plus a parametrised ALU decoder generating `alucontrol` from an internal `aluop` and `funct`. It sits between the instruction register and the shared-ALU datapath. It is the successor to the combinational ALU decoder: it adds sequencing, a wider ALU-control encoding, immediate-logic ops and illegal-opcode reporting.

## Interface
- `ALUCTRL_W`, 3: width of `alucontrol`; legal values 3 or 4.
- `EXT_OPS`, 0: 1 enables nor/xor funct codes and andi/ori/slti opcodes; requires `ALUCTRL_W`=4.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `op`  in  6  opcode from instruction register; stable from DECODE until next FETCH.
- `funct`  in  6  instruction[5:0].
- `zero`  in  1  ALU zero flag.
- `pcen`  out  1  PC write enable.
- `memwrite`, `irwrite`, `regwrite`  out  1 each  write enables.
- `alusrca`, `iord`, `memtoreg`, `regdst`  out  1 each  datapath mux selects.
- `alusrcb`  out  2  ALU B select: 00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- `pcsrc`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `alucontrol`  out  `ALUCTRL_W`  ALU operation.
- `illegal`  out  1  one-cycle pulse on undecodable op/funct.
- `instr_done`  out  1  one-cycle pulse in an instruction's final state.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, IMMEXEC, IMMWB, JUMP.
- FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1 -> DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target). lw(100011)/sw(101011) -> MEMADR; R-type(000000) -> EXECUTE; beq(000100) -> BRANCH; addi(001000), plus andi(001100)/ori(001101)/slti(001010) when EXT_OPS -> IMMEXEC; j(000010) -> JUMP; anything else -> FETCH with `illegal`=1.
- MEMADR: alusrca=1, alusrcb=10, aluop=00; lw -> MEMRD, sw -> MEMWR. MEMRD: iord=1 -> MEMWB. MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH. MEMWR: iord=1, memwrite=1 -> FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB. ALUWB: regdst=1, memtoreg=0, regwrite=1 -> FETCH; undecodable funct: regwrite forced 0, `illegal`=1.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 -> FETCH. JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- IMMEXEC: alusrca=1, alusrcb=10, aluop=00 for addi, 11 otherwise -> IMMWB. IMMWB: regdst=0, memtoreg=0, regwrite=1 -> FETCH.
- `pcen` = pcwrite | (branch & zero), combinational on `zero`.
- `instr_done` high in MEMWB, MEMWR, ALUWB, BRANCH, IMMWB, JUMP.
- Unlisted outputs 0 in every state.
- ALU decode, 3-bit: add 010, sub 110, and 000, or 001, slt 111. 4-bit: add 0010, sub 0110, and 0000, or 0001, slt 0111, nor 1100, xor 0011.
- aluop 00 -> add; 01 -> sub; 10 -> funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, plus 100111 nor and 100110 xor when EXT_OPS; 11 -> op andi->and, ori->or, slti->slt.
- Unknown funct -> `alucontrol` = add encoding.

## Timing
- Cycles per instruction, FETCH to FETCH: lw 5, sw 4, R-type 4, addi/imm 4, beq 3, j 3, illegal 2.
- State register updates on rising `clk`; all outputs are decoded from the state only, except `pcen`, `alucontrol` and DECODE/ALUWB `illegal`, which also depend on inputs.
- Reset: state <= FETCH at the next edge. While `reset`=1: pcen, irwrite, memwrite, regwrite, illegal and instr_done are forced 0; other outputs take FETCH values.
- Reset asserted mid-instruction aborts it; no write enable is asserted in that cycle or after it.

## Structure
- Package `mips_ctrl_pkg`: opcode and funct constants, state enum, aluop constants, 3- and 4-bit alucontrol constants.
- Sub-module `alu_decoder_ext` (combinational; parameters ALUCTRL_W and EXT_OPS; inputs aluop, op, funct) instantiated once. The FSM lives in the top.

## Test plan
- Reset 2 cycles, then op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; instr_done pulse in cycle 5.
- R-type op=000000, funct=100010 -> in EXECUTE alucontrol=110 (W=3) or 0110 (W=4); regwrite=1 with regdst=1 in ALUWB.
- beq with zero=1 in BRANCH -> pcen=1, pcsrc=01; repeat with zero=0 -> pcen=0; 3 cycles.
- EXT_OPS=1, ori op=001101 -> IMMEXEC alucontrol=0001; funct=100111 -> 1100.
- op=111111 -> illegal pulse in DECODE, next state FETCH, no write enable; EXT_OPS=0 with funct=100111 -> illegal in ALUWB, regwrite=0.
- Reset asserted in MEMRD -> no regwrite; FETCH on the cycle after reset deasserts.
